// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the UART transmitter: the CPU drives address,
// store data and store enable; the block answers with read data and a hit flag.
interface mmio_uart_tx_if;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_io;
    logic        io_hit;

    modport master (
        output address_dmem,
        output data,
        output wren,
        input  q_io,
        input  io_hit
    );

    modport slave (
        input  address_dmem,
        input  data,
        input  wren,
        output q_io,
        output io_hit
    );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores to DATA_ADDR queue bytes in a
// small FIFO, and a start/data/stop FSM shifts them out LSB first on tx.
// Loads from STATUS_ADDR return {overflow, busy, empty, full}. A store to
// STATUS_ADDR with bit 3 set clears the sticky overflow flag.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] DATA_ADDR    = 32'd4098,
    parameter logic [31:0] STATUS_ADDR  = 32'd4099
) (
    input  logic                 clock,
    input  logic                 reset,
    mmio_uart_tx_if.slave        bus,
    output logic                 tx
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] DEPTH_COUNT  = PW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          overflow_q, overflow_d;
    logic          tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bitIdx_q, bitIdx_d;
    logic [7:0]    fifoMem [FIFO_DEPTH];

    logic [PW-1:0] count;
    logic          full;
    logic          empty;
    logic          busy;
    logic          dataHit;
    logic          statusHit;
    logic          pushReq;
    logic          push;
    logic          pop;
    logic          clearReq;
    logic          timerDone;
    logic          unusedData;

    // The extra wrap bit on each pointer lets count reach FIFO_DEPTH.
    assign count     = wptr_q - rptr_q;
    assign full      = (count == DEPTH_COUNT);
    assign empty     = (count == '0);
    assign busy      = (state_q != IDLE) || !empty;
    assign dataHit   = (bus.address_dmem == DATA_ADDR);
    assign statusHit = (bus.address_dmem == STATUS_ADDR);
    assign pushReq   = bus.wren && dataHit;
    assign push      = pushReq && !full;
    assign pop       = (state_q == IDLE) && !empty;
    assign clearReq  = bus.wren && statusHit && bus.data[3];
    assign timerDone = (timer_q == '0);
    assign unusedData = ^bus.data[31:8];

    assign bus.io_hit = dataHit || statusHit;
    assign bus.q_io   = statusHit ? {28'b0, overflow_q, busy, empty, full} : 32'b0;
    assign tx         = tx_q;

    // State and datapath registers; reset discards any frame in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            timer_q    <= '0;
            bitIdx_q   <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            timer_q    <= timer_d;
            bitIdx_q   <= bitIdx_d;
        end
    end

    // Byte storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wptr_q[AW-1:0]] <= bus.data[7:0];
        end
    end

    // FIFO pointers and sticky overflow; a drop on the same edge as a clear wins.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (clearReq) begin
            overflow_d = 1'b0;
        end
        if (pushReq && full) begin
            overflow_d = 1'b1;
        end
    end

    // Next-state logic: each non-idle state lasts until the baud timer expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = START;
            START:   if (timerDone) state_d = DATA;
            DATA:    if (timerDone && (bitIdx_q == 3'd7)) state_d = STOP;
            STOP:    if (timerDone) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Serializer outputs: drive tx, shift the byte and reload the timer per bit.
    always_comb begin
        tx_d     = tx_q;
        shift_d  = shift_q;
        bitIdx_d = bitIdx_q;
        timer_d  = timerDone ? timer_q : timer_q - 1'b1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    shift_d = fifoMem[rptr_q[AW-1:0]];
                    tx_d    = 1'b0;
                    timer_d = TIMER_RELOAD;
                end else begin
                    tx_d = 1'b1;
                end
            end
            START: begin
                if (timerDone) begin
                    tx_d     = shift_q[0];
                    timer_d  = TIMER_RELOAD;
                    bitIdx_d = 3'd0;
                end
            end
            DATA: begin
                if (timerDone) begin
                    timer_d = TIMER_RELOAD;
                    if (bitIdx_q != 3'd7) begin
                        shift_d  = shift_q >> 1;
                        tx_d     = shift_q[1];
                        bitIdx_d = bitIdx_q + 3'd1;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with a short bit period so whole
// frames fit in a few dozen cycles.
module tb_mmio_uart_tx;

    localparam int          CPB         = 4;
    localparam int          DEPTH       = 8;
    localparam logic [31:0] DATA_ADDR   = 32'd4098;
    localparam logic [31:0] STATUS_ADDR = 32'd4099;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wren;
        logic        expHit;
        logic [31:0] expQ;
        logic [31:0] expStatus;
    } vec_t;

    logic clock;
    logic reset;
    logic tx;

    int   compared   = 0;
    int   mismatched = 0;
    bit   logOn      = 0;
    logic txLog [$];
    vec_t vectors [8];

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_ADDR    (DATA_ADDR),
        .STATUS_ADDR  (STATUS_ADDR)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (logOn) txLog.push_back(tx);
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
        bus.address_dmem = addr;
        bus.data         = wdata;
        bus.wren         = we;
    endtask

    task automatic storeWord(input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(addr, wdata, 1'b1);
        tick();
        applyStimulus(STATUS_ADDR, 32'h0, 1'b0);
        #1;
    endtask

    // 40 cycles of start/data/stop followed by one idle-high cycle.
    function automatic logic [40:0] expectedFrame(input logic [7:0] b);
        logic [9:0]  bits;
        logic [40:0] f;
        bits = {1'b1, b, 1'b0};
        for (int k = 0; k < 40; k++) f[k] = bits[k / CPB];
        f[40] = 1'b1;
        return f;
    endfunction

    task automatic sendAndCheck(input logic [7:0] b, input string name);
        logic [40:0] seen;
        logic [39:0] busySeen;
        storeWord(DATA_ADDR, {24'hABCDEF, b});
        for (int k = 0; k < 41; k++) begin
            tick();
            seen[k] = tx;
            if (k < 40) busySeen[k] = bus.q_io[2];
        end
        checkOutput({name, "_tx"}, 64'(seen), 64'(expectedFrame(b)));
        checkOutput({name, "_busy"}, 64'(busySeen), 64'({40{1'b1}}));
        checkOutput({name, "_status"}, 64'(bus.q_io), 64'h2);
    endtask

    initial begin
        logic [40:0] frameSeen;
        logic        anyLow;

        vectors[0] = '{32'd4097,       32'h55,       1'b1, 1'b0, 32'h0, 32'h2};
        vectors[1] = '{32'd4100,       32'hAA,       1'b1, 1'b0, 32'h0, 32'h2};
        vectors[2] = '{32'd4098,       32'h0,        1'b0, 1'b1, 32'h0, 32'h2};
        vectors[3] = '{32'd4099,       32'h0,        1'b0, 1'b1, 32'h2, 32'h2};
        vectors[4] = '{32'd4099,       32'h8,        1'b1, 1'b1, 32'h2, 32'h2};
        vectors[5] = '{32'd0,          32'hFF,       1'b1, 1'b0, 32'h0, 32'h2};
        vectors[6] = '{32'd4099,       32'hFFFFFFF7, 1'b1, 1'b1, 32'h2, 32'h2};
        vectors[7] = '{32'h0001_1002,  32'h77,       1'b1, 1'b0, 32'h0, 32'h2};

        reset = 1'b1;
        applyStimulus(STATUS_ADDR, 32'h0, 1'b0);
        tick();
        tick();
        checkOutput("reset_tx", 64'(tx), 64'h1);
        checkOutput("reset_status", 64'(bus.q_io), 64'h2);
        reset = 1'b0;
        tick();
        checkOutput("post_reset_tx", 64'(tx), 64'h1);

        // Address decode and non-pushing stores while idle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].addr, vectors[i].data, vectors[i].wren);
            #1;
            checkOutput($sformatf("vec%0d_hit", i), 64'(bus.io_hit), 64'(vectors[i].expHit));
            checkOutput($sformatf("vec%0d_q", i), 64'(bus.q_io), 64'(vectors[i].expQ));
            tick();
            applyStimulus(STATUS_ADDR, 32'h0, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d_tx", i), 64'(tx), 64'h1);
            checkOutput($sformatf("vec%0d_status", i), 64'(bus.q_io), 64'(vectors[i].expStatus));
        end

        sendAndCheck(8'hA5, "frameA5");

        // Pointer wrap: one byte per frame, 20 frames.
        for (int i = 0; i < 20; i++) begin
            sendAndCheck(8'(i * 37 + 5), $sformatf("wrap%0d", i));
        end
        checkOutput("wrap_no_overflow", 64'(bus.q_io[3]), 64'h0);

        // Ten back-to-back stores: nine accepted, the tenth dropped.
        applyStimulus(DATA_ADDR, 32'h1, 1'b1);
        tick();
        logOn = 1;
        for (int i = 2; i <= 10; i++) begin
            applyStimulus(DATA_ADDR, 32'(i), 1'b1);
            tick();
        end
        applyStimulus(STATUS_ADDR, 32'h0, 1'b0);
        #1;
        checkOutput("b2b_status_full", 64'(bus.q_io), 64'hD);
        for (int k = 9; k < 9 * 41; k++) tick();
        logOn = 0;
        for (int f = 0; f < 9; f++) begin
            for (int j = 0; j < 41; j++) frameSeen[j] = txLog[f * 41 + j];
            checkOutput($sformatf("b2b_frame%0d", f + 1), 64'(frameSeen), 64'(expectedFrame(8'(f + 1))));
        end
        checkOutput("b2b_status_drained", 64'(bus.q_io), 64'hA);
        txLog.delete();

        // Overflow is only cleared by a control store with bit 3 set.
        applyStimulus(STATUS_ADDR, 32'h0, 1'b1);
        tick();
        checkOutput("clear0_keeps_overflow", 64'(bus.q_io), 64'hA);
        applyStimulus(STATUS_ADDR, 32'h8, 1'b1);
        tick();
        checkOutput("clear8_overflow", 64'(bus.q_io), 64'h2);
        applyStimulus(STATUS_ADDR, 32'h0, 1'b0);

        // Reset in the middle of a frame with another byte queued.
        applyStimulus(DATA_ADDR, 32'h55, 1'b1);
        tick();
        applyStimulus(DATA_ADDR, 32'h66, 1'b1);
        tick();
        applyStimulus(STATUS_ADDR, 32'h0, 1'b0);
        for (int k = 0; k < 13; k++) tick();
        checkOutput("midframe_status", 64'(bus.q_io), 64'h4);
        reset = 1'b1;
        tick();
        checkOutput("midreset_tx", 64'(tx), 64'h1);
        checkOutput("midreset_status", 64'(bus.q_io), 64'h2);
        reset = 1'b0;
        anyLow = 1'b0;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (tx !== 1'b1) anyLow = 1'b1;
        end
        checkOutput("after_reset_idle_tx", 64'(anyLow), 64'h0);
        checkOutput("after_reset_status", 64'(bus.q_io), 64'h2);
        sendAndCheck(8'h3C, "post_reset_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the processor's data-memory bus; a responder to CPU stores and loads, alongside the switch-read and LED-write I/O decode.
- CPU stores bytes to a data address. They queue in a small FIFO and are serialized 8N1, LSB first, on a single `tx` pin.
- CPU loads from a status address to poll FIFO and transmitter state.
- The top level muxes `q_io` onto `q_dmem` when `io_hit` is high.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 2.
- FIFO_DEPTH, 8, byte FIFO entries; power of 2, minimum 2.
- DATA_ADDR, 32'd4098, store target for TX bytes.
- STATUS_ADDR, 32'd4099, load/store target for status and control.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- address_dmem  in  32  processor data address.
- data  in  32  processor store data.
- wren  in  1  processor store enable.
- q_io  out  32  read data for status loads; combinational from registered state.
- io_hit  out  1  combinational; 1 when address_dmem equals DATA_ADDR or STATUS_ADDR.
- tx  out  1  serial output, registered; idle high.

Behaviour:
- Reset (sampled on posedge clock with reset=1):
  - tx=1; FIFO empty (pointers 0); overflow=0; FSM=IDLE; bit counter and baud timer = 0.
  - Takes priority over all other activity, including mid-frame: on the next edge tx returns to 1 and queued bytes are discarded.
- Push:
  - Occurs when wren=1, address_dmem==DATA_ADDR, and full=0 (evaluated before the edge). data[7:0] is written; data[31:8] is ignored.
  - If full=1 the byte is dropped and overflow is set (sticky). This holds even if a pop occurs on the same edge: a full FIFO never accepts.
- Control store:
  - Store to STATUS_ADDR with data[3]=1 clears overflow. All other bits are ignored.
  - If the same edge also sets overflow, set wins.
- Status read value (STATUS_ADDR): {28'b0, overflow, busy, empty, full}.
  - full: count==FIFO_DEPTH.
  - empty: count==0.
  - busy: FSM!=IDLE or empty==0.
  - q_io=0 whenever address_dmem!=STATUS_ADDR, including reads of DATA_ADDR.
- FIFO:
  - Read/write pointers carry one extra wrap bit; count = wptr-rptr.
  - Simultaneous push and pop when not full: both occur, count unchanged.
  - Wrap-around is transparent.
- FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: if not empty, pop into an 8-bit shift register, set tx=0, load baud timer with CLKS_PER_BIT-1, go to START. Otherwise tx=1.
  - START: when the timer reaches 0, tx=shift[0], reload timer, bit index=0, go to DATA.
  - DATA: when the timer reaches 0:
    - if bit index<7: shift right, tx=next bit, index+1;
    - at index 7: tx=1, go to STOP. Reload the timer on each transition.
  - STOP: when the timer reaches 0, go to IDLE. If the FIFO is non-empty, the IDLE pop happens on the following edge, so there is exactly one extra idle-high cycle between frames.
  - The timer decrements by 1 each cycle while non-zero.
- Latency and timing:
  - Store committed at edge N into an empty, idle block: pop and tx falls at edge N+1.
  - Start bit, each data bit and stop bit each last CLKS_PER_BIT cycles.
  - Frame = 10*CLKS_PER_BIT cycles.
- Capacity with back-to-back stores: 1 byte in the shifter plus FIFO_DEPTH bytes queued.
- Arithmetic: timer width clog2(CLKS_PER_BIT); counters never wrap negative.

Test Plan:
- CLKS_PER_BIT=4; store 0x000000A5 to 4098 at edge N -> tx=0 for edges N+1..N+4; then data bits 1,0,1,0,0,1,0,1 (4 cycles each); then stop=1 for 4 cycles; busy=1 from N+1 to N+40, then status=0x2.
- Ten back-to-back stores 0x01..0x0A, FIFO_DEPTH=8:
  - bytes 0x01..0x09 accepted, 0x0A dropped;
  - status reads 0x0D (overflow, busy, full) after the 10th store;
  - tx emits 0x01..0x09 in order with one idle cycle between frames.
- Overflow set, then store 0x8 to 4099 -> status bit3=0 on the next cycle; a store of 0x0 to 4099 leaves it set.
- Assert reset at cycle 15 of a frame -> next edge: tx=1, status=0x2, FIFO empty; a new store after deassert transmits normally.
- Stores to 4097 and 4100 -> no push, io_hit=0, q_io=0, tx stays 1. Load from 4098 -> io_hit=1, q_io=0.
- Wrap check: 20 stores paced one per frame -> every byte transmitted correctly across pointer wrap; overflow stays 0.
